seq_multiplier: RTL and testbench



---
 rtl/mul_pkg.sv | 28 ++
 rtl/mul_step.sv | 41 ++++
 rtl/seq_multiplier.sv | 160 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - mul_state_e   : controller states (IDLE, CALC, FIX, DONE)
//   - iter_count()  : number of CALC cycles needed for a WIDTH/STEP pair
//   - step_is_legal(): true when STEP evenly divides WIDTH
// ---------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // Each CALC cycle retires STEP multiplier bits.
    function automatic int iter_count(input int width, input int step);
        return width / step;
    endfunction

    // STEP must be a positive divisor of WIDTH so the last CALC cycle
    // consumes exactly the top multiplier bits.
    function automatic bit step_is_legal(input int width, input int step);
        return (step > 0) && (step <= width) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
// Combinational partial-product adder for one CALC cycle. Adds the
// multiplicand magnitude, shifted to each selected bit position, into the
// running accumulator.
//
// Ports:
//   i_acc      [2*WIDTH-1:0]  current accumulator
//   i_mcand    [WIDTH-1:0]    multiplicand magnitude |a|
//   i_bits     [STEP-1:0]     multiplier bits retired this cycle (LSB first)
//   i_pos      [POS_W-1:0]    bit position of i_bits[0] within |b|
//   o_acc_next [2*WIDTH-1:0]  accumulator after this cycle's additions
// ---------------------------------------------------------------------------
module mul_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int POS_W = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [STEP-1:0]    i_bits,
    input  logic [POS_W-1:0]   i_pos,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [2*WIDTH-1:0] w_mcand_ext;

    assign w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};

    // Sum of the STEP shifted partial products. The accumulator is 2*WIDTH
    // bits wide, so no partial sum of unsigned magnitudes can overflow it.
    always_comb begin
        o_acc_next = i_acc;
        for (int j = 0; j < STEP; j++) begin
            if (i_bits[j]) begin
                o_acc_next = o_acc_next + (w_mcand_ext << (int'(i_pos) + j));
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle shift-add multiplier with valid/ready handshakes on both
// sides. Operands are converted to magnitudes on accept, multiplied
// unsigned over WIDTH/STEP cycles, then the sign is applied in one FIX
// cycle. One operation is in flight at a time.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to IDLE, discards any result
//   in_valid   operands present on a/b/is_signed
//   in_ready   block can accept (IDLE only)
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  1: two's-complement operands and product, 0: unsigned
//   out_valid  y holds a completed product
//   out_ready  consumer accepts y
//   y          2*WIDTH-bit product
//   busy       high in CALC or FIX
// ---------------------------------------------------------------------------
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               busy
);

    localparam int ITER  = iter_count(WIDTH, STEP);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int POS_W = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    // Reject illegal STEP at elaboration time.
    if (!step_is_legal(WIDTH, STEP)) begin : g_bad_step
        $error("seq_multiplier: STEP must evenly divide WIDTH");
    end

    mul_state_e r_state;
    mul_state_e w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_y;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [POS_W-1:0]   w_pos;
    logic [2*WIDTH-1:0] w_acc_next;

    // Negating the most-negative value yields the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    assign w_abs_a = (is_signed && a[WIDTH-1]) ? (-a) : a;
    assign w_abs_b = (is_signed && b[WIDTH-1]) ? (-b) : b;

    assign w_pos = POS_W'(r_count) * POS_W'(STEP);

    mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .POS_W (POS_W)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .i_bits     (r_mplier[STEP-1:0]),
        .i_pos      (w_pos),
        .o_acc_next (w_acc_next)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC) || (r_state == FIX);
    assign y         = r_y;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. flush overrides every transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid)            w_next_state = CALC;
            CALC: if (r_count == LAST_CNT) w_next_state = FIX;
            FIX:                           w_next_state = DONE;
            DONE: if (out_ready)           w_next_state = IDLE;
            default:                       w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    // Datapath: operands and sign are captured only on the accept edge;
    // the multiplier register shifts right so its low STEP bits are always
    // the ones being retired this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_acc    <= w_acc_next;
                        r_mplier <= r_mplier >> STEP;
                        r_count  <= r_count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_y <= r_neg ? (-r_acc) : r_acc;
                    end
                end
                DONE: begin
                    if (flush) begin
                        r_y <= '0;
                    end
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Drives two multiplier instances (STEP=1 and STEP=4) with shared stimulus
// and checks products, latency, handshakes, reset and flush behaviour.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        is_signed;
    logic        out_ready;
    logic [31:0] opA;
    logic [31:0] opB;

    logic        in_ready1, out_valid1, busy1;
    logic        in_ready4, out_valid4, busy4;
    logic [63:0] y1, y4;

    logic [63:0] q1[$];
    logic [63:0] q4[$];

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32), .STEP(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (opA),
        .b         (opB),
        .is_signed (is_signed),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .y         (y1),
        .busy      (busy1)
    );

    seq_multiplier #(.WIDTH(32), .STEP(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (opA),
        .b         (opB),
        .is_signed (is_signed),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .y         (y4),
        .busy      (busy4)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference product computed with full-width arithmetic.
    function automatic logic [63:0] mulModel(input logic [31:0] x,
                                             input logic [31:0] z,
                                             input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sz;
        sx = {{32{x[31]}}, x};
        sz = {{32{z[31]}}, z};
        if (s) return 64'(sx * sz);
        return {32'b0, x} * {32'b0, z};
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready1"},  64'(in_ready1),  64'd1);
        checkOutput({tag, "_in_ready4"},  64'(in_ready4),  64'd1);
        checkOutput({tag, "_out_valid1"}, 64'(out_valid1), 64'd0);
        checkOutput({tag, "_out_valid4"}, 64'(out_valid4), 64'd0);
        checkOutput({tag, "_busy1"},      64'(busy1),      64'd0);
        checkOutput({tag, "_busy4"},      64'(busy4),      64'd0);
    endtask

    // Present one operation for a single accept edge, then scramble the
    // operand inputs so any late sampling shows up as a wrong product.
    task automatic applyStimulus(input logic [31:0] xa, input logic [31:0] xb,
                                 input logic s);
        @(negedge clk);
        opA       = xa;
        opB       = xb;
        is_signed = s;
        in_valid  = 1'b1;
        checkOutput("accept_in_ready1", 64'(in_ready1), 64'd1);
        checkOutput("accept_in_ready4", 64'(in_ready4), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opA       = $urandom;
        opB       = $urandom;
        is_signed = ~s;
    endtask

    // mode 0: normal handshake, 1: 5 cycles of backpressure first,
    // 2: flush in DONE instead of handshake.
    task automatic runOp(input logic [31:0] xa, input logic [31:0] xb,
                         input logic s, input logic [63:0] expected,
                         input int mode);
        logic [63:0] e1;
        logic [63:0] e4;
        int cnt;
        int lat1;
        int lat4;
        int busyCnt;
        q1.delete();
        q4.delete();
        q1.push_back(expected);
        q4.push_back(expected);
        applyStimulus(xa, xb, s);
        cnt = 0; lat1 = 0; lat4 = 0; busyCnt = 0; e1 = '0; e4 = '0;
        while ((lat1 == 0 || lat4 == 0) && cnt < 80) begin
            if (busy4) busyCnt++;
            if (out_valid1 && lat1 == 0) begin
                lat1 = cnt;
                e1 = q1.pop_front();
                checkOutput("y_step1", y1, e1);
            end
            if (out_valid4 && lat4 == 0) begin
                lat4 = cnt;
                e4 = q4.pop_front();
                checkOutput("y_step4", y4, e4);
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("latency_step1", 64'(lat1), 64'd33);
        checkOutput("latency_step4", 64'(lat4), 64'd9);
        checkOutput("busy_cycles_step4", 64'(busyCnt), 64'd9);

        if (mode == 1) begin
            repeat (5) begin
                @(negedge clk);
                checkOutput("bp_y1",        y1,               e1);
                checkOutput("bp_y4",        y4,               e4);
                checkOutput("bp_out_valid1", 64'(out_valid1), 64'd1);
                checkOutput("bp_out_valid4", 64'(out_valid4), 64'd1);
                checkOutput("bp_in_ready1",  64'(in_ready1),  64'd0);
                checkOutput("bp_in_ready4",  64'(in_ready4),  64'd0);
            end
        end

        if (mode == 2) begin
            @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            checkIdle("flush_done");
        end else begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkIdle("handshake");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] rz;
        logic        rs;
        int          seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        opA       = '0;
        opB       = '0;

        #1;
        checkIdle("reset");
        checkOutput("reset_y1", y1, 64'd0);
        checkOutput("reset_y4", y4, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed products");
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
        runOp(32'hFFFF_FFFF, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1);
        runOp(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
        runOp(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, 0);
        runOp(32'd12345,     32'd6789,      1'b0, 64'd83810205,            0);
        runOp(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0);
        runOp(32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0,                   0);

        $display("[TB] random products");
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            rz = $urandom;
            rs = 1'($urandom_range(0, 1));
            runOp(rx, rz, rs, mulModel(rx, rz, rs), 0);
        end

        $display("[TB] reset during CALC");
        applyStimulus(32'd1234, 32'd5678, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("midreset");
        checkOutput("midreset_y1", y1, 64'd0);
        checkOutput("midreset_y4", y4, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runOp(32'd3, 32'd7, 1'b0, 64'd21, 0);

        $display("[TB] flush during CALC and DONE");
        applyStimulus(32'd100, 32'd200, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkIdle("flush_calc");
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid1 || out_valid4) seen = 1;
        end
        checkOutput("flush_calc_no_result", 64'(seen), 64'd0);
        runOp(32'd9, 32'd9, 1'b0, 64'd81, 2);
        runOp(32'd2, 32'd2, 1'b0, 64'd4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
